// File: rtl/strobe_period_meter.sv
// Measures enable-qualified ticks between successive strobes and tracks lock on repeated equal periods.
// Latency: strobe at cycle t gives period_valid at t+1; no backpressure, one measurement per cycle.
module strobe_period_meter #(
  parameter int WIDTH      = 25,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             locked
);

  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic {ARM, MEASURE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tick_cnt, tick_cnt_nxt;
  logic             sat_flag, sat_flag_nxt;
  logic [WIDTH-1:0] last_period, last_period_nxt;
  logic             last_vld, last_vld_nxt;
  logic [MW-1:0]    match_cnt, match_cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             period_valid_nxt;
  logic             overflow_nxt;
  logic             locked_nxt;
  logic [WIDTH-1:0] first_tick;
  logic             period_match;

  // The enable coinciding with a strobe belongs to the interval that strobe opens.
  assign first_tick   = {{(WIDTH-1){1'b0}}, enable};
  assign period_match = last_vld && (tick_cnt == last_period);

  always_comb begin
    state_nxt        = state;
    tick_cnt_nxt     = tick_cnt;
    sat_flag_nxt     = sat_flag;
    last_period_nxt  = last_period;
    last_vld_nxt     = last_vld;
    match_cnt_nxt    = match_cnt;
    period_nxt       = period;
    period_valid_nxt = 1'b0;
    overflow_nxt     = overflow;
    locked_nxt       = locked;

    case (state)
      ARM: begin
        tick_cnt_nxt = '0;
        if (strobe) begin
          state_nxt    = MEASURE;
          tick_cnt_nxt = first_tick;
        end
      end

      MEASURE: begin
        if (strobe) begin
          period_nxt       = tick_cnt;
          overflow_nxt     = sat_flag;
          period_valid_nxt = 1'b1;
          tick_cnt_nxt     = first_tick;
          sat_flag_nxt     = 1'b0;

          // A saturated interval is not a trustworthy period, so it restarts lock acquisition.
          if (sat_flag) begin
            match_cnt_nxt = '0;
            last_vld_nxt  = 1'b0;
            locked_nxt    = 1'b0;
          end else begin
            if (period_match) begin
              match_cnt_nxt = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MW'(1);
            end else begin
              match_cnt_nxt = '0;
            end
            last_period_nxt = tick_cnt;
            last_vld_nxt    = 1'b1;
            locked_nxt      = (match_cnt_nxt == MATCH_MAX);
          end
        end else if (enable) begin
          if (tick_cnt == CNT_MAX) begin
            sat_flag_nxt = 1'b1;
          end else begin
            tick_cnt_nxt = tick_cnt + WIDTH'(1);
          end
        end
      end

      default: begin
        state_nxt    = ARM;
        tick_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARM;
      tick_cnt     <= '0;
      sat_flag     <= 1'b0;
      last_period  <= '0;
      last_vld     <= 1'b0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick_cnt     <= tick_cnt_nxt;
      sat_flag     <= sat_flag_nxt;
      last_period  <= last_period_nxt;
      last_vld     <= last_vld_nxt;
      match_cnt    <= match_cnt_nxt;
      period       <= period_nxt;
      period_valid <= period_valid_nxt;
      overflow     <= overflow_nxt;
      locked       <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_strobe_period_meter.sv
// Scoreboard bench for strobe_period_meter: a 25-bit and a 4-bit instance share one stimulus stream.
module tb_strobe_period_meter;

  localparam int LOCKN = 2;

  logic        clk = 1'b0;
  logic        rst, enable, strobe;
  logic [24:0] period;
  logic        period_valid, overflow, locked;
  logic [3:0]  period4;
  logic        period_valid4, overflow4, locked4;

  always #5 clk = ~clk;

  strobe_period_meter #(.WIDTH(25), .LOCK_COUNT(LOCKN)) dut (
    .clk(clk), .rst(rst), .enable(enable), .strobe(strobe),
    .period(period), .period_valid(period_valid), .overflow(overflow), .locked(locked)
  );

  strobe_period_meter #(.WIDTH(4), .LOCK_COUNT(LOCKN)) dut_w4 (
    .clk(clk), .rst(rst), .enable(enable), .strobe(strobe),
    .period(period4), .period_valid(period_valid4), .overflow(overflow4), .locked(locked4)
  );

  typedef struct packed {
    logic [31:0] p0;
    logic [31:0] p1;
    logic        ov0;
    logic        ov1;
    logic        lk0;
    logic        lk1;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          armed = 1'b0;
  int          count = 0;
  int          run[2];
  bit          lv[2];
  int          lp[2];
  logic [31:0] hp[2];
  logic        hov[2];
  logic        hlk[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Lock = at least LOCKN consecutive equal non-overflowed periods ending here.
  task automatic model_meas(input int w, input int p, input bit ov, output bit lk);
    if (ov) begin
      run[w] = 0;
      lv[w]  = 1'b0;
      lk     = 1'b0;
    end else begin
      if (lv[w] && lp[w] == p) run[w]++;
      else run[w] = 1;
      lp[w] = p;
      lv[w] = 1'b1;
      lk    = (run[w] >= LOCKN);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s);
    exp_t x;
    bit   lk;
    rst    = r;
    enable = e;
    strobe = s;
    if (r) begin
      armed = 1'b0;
      count = 0;
      for (int w = 0; w < 2; w++) begin run[w] = 0; lv[w] = 1'b0; end
    end else if (s) begin
      if (armed) begin
        x.p0  = count;
        x.ov0 = 1'b0;
        model_meas(0, count, 1'b0, lk);
        x.lk0 = lk;
        x.p1  = (count > 15) ? 15 : count;
        x.ov1 = (count > 15);
        model_meas(1, int'(x.p1), x.ov1, lk);
        x.lk1 = lk;
        sbq.push_back(x);
      end
      armed = 1'b1;
      count = int'(e);
    end else if (armed) begin
      count += int'(e);
    end

    @(posedge clk);
    #1;
    chk("period_valid", 32'(period_valid), 32'(sbq.size()));
    chk("period_valid_w4", 32'(period_valid4), 32'(sbq.size()));
    if (r) begin
      for (int w = 0; w < 2; w++) begin hp[w] = '0; hov[w] = 1'b0; hlk[w] = 1'b0; end
    end
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      hp[0] = x.p0; hov[0] = x.ov0; hlk[0] = x.lk0;
      hp[1] = x.p1; hov[1] = x.ov1; hlk[1] = x.lk1;
    end
    chk("period", 32'(period), hp[0]);
    chk("overflow", 32'(overflow), 32'(hov[0]));
    chk("locked", 32'(locked), 32'(hlk[0]));
    chk("period_w4", 32'(period4), hp[1]);
    chk("overflow_w4", 32'(overflow4), 32'(hov[1]));
    chk("locked_w4", 32'(locked4), 32'(hlk[1]));
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      run[w] = 0; lv[w] = 1'b0; lp[w] = 0; hp[w] = '0; hov[w] = 1'b0; hlk[w] = 1'b0;
    end
    rst = 1'b1; enable = 1'b0; strobe = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Arming then two 6-tick intervals with enable held high; lock on the second.
    step(1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // Lock loss: a third 6 then a 7.
    repeat (5) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // Alternating enable, strobe every 8 cycles: 4 ticks per interval.
    for (int k = 0; k <= 32; k++) step(1'b0, (k % 2) == 0, (k % 8) == 0);

    // Zero period, then an enable coinciding with a strobe opening a 1-tick interval.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Saturation on the 4-bit instance: 20 ticks, then two clean 15-tick intervals.
    repeat (20) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (2) begin
      repeat (15) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end

    // Strobes in consecutive cycles.
    repeat (6) step(1'b0, 1'(($urandom % 2)), 1'b1);

    // Reset mid-interval, re-arm, then reset coincident with a strobe.
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic with occasional resets.
    repeat (400) step($urandom_range(0, 49) == 0, 1'(($urandom % 2)), $urandom_range(0, 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/strobe_period_meter.md
# strobe_period_meter

Measures the spacing between incoming single-cycle strobes and counts qualifying `enable` ticks in each interval. It reports each interval as a registered period word with a one-cycle valid pulse. It is the receiving end of the team's strobe-generating counters: it recovers the programmed divide ratio from a strobe stream, and checks lock against a reference tick domain. Typical uses are clock-divider self-check, baud/tick recovery and frequency-ratio monitoring.

## Interface
- `WIDTH`, default 25: width of the tick counter and the reported period.
- `LOCK_COUNT`, default 2: consecutive identical, non-overflowed periods required to assert `locked`. Legal range is 1..255.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  tick qualifier; each high cycle is one counted tick.
- `strobe`  in  1  event input, sampled every cycle; each high cycle is one event, and no edge detection is applied.
- `period`  out  WIDTH  ticks in the last completed interval. Held between updates.
- `period_valid`  out  1  one-cycle pulse when `period` and `overflow` update.
- `overflow`  out  1  the reported interval saturated the counter. Qualified by `period_valid` and held with `period`.
- `locked`  out  1  `LOCK_COUNT` consecutive equal, non-overflowed periods have been seen.

## Operation
- States:
  - ARM: after reset, waiting for the first strobe.
  - MEASURE: counting ticks.
- ARM:
  - `tick_cnt` is held at 0.
  - On `strobe`, go to MEASURE. Load `tick_cnt` with `enable ? 1 : 0`.
  - No `period_valid` is generated for the arming strobe.
- MEASURE, no strobe: `tick_cnt <= tick_cnt + enable`, saturating at 2^WIDTH-1. Set internal `sat_flag` when an increment is attempted at the maximum.
- MEASURE, strobe:
  - `period <= tick_cnt`, `overflow <= sat_flag`, and `period_valid` pulses.
  - `tick_cnt <= enable ? 1 : 0`, and `sat_flag` clears.
  - Stay in MEASURE.
- Interval definition:
  - For strobes at cycles t0 < t1, the period is the number of cycles in [t0, t1) with `enable` high.
  - `enable` in the same cycle as a closing strobe counts toward the next interval.
- Period 0 is legal and is reported normally. This covers back-to-back strobes with `enable` low.
- Lock tracking, on each `period_valid`:
  - If `overflow` is 1: clear `match_cnt`, clear `last_period` valid, and set `locked` to 0.
  - Otherwise, if `last_period` is valid and the new period equals `last_period`: `match_cnt <= min(match_cnt+1, LOCK_COUNT-1)`.
  - Otherwise: `match_cnt <= 0`.
  - In both non-overflow cases, `last_period <= new period` and mark it valid.
  - `locked` is set exactly when the updated `match_cnt` equals `LOCK_COUNT-1` and the measurement is non-overflowed. With `LOCK_COUNT=1`, this is every non-overflowed measurement.
- `locked` changes only at `period_valid` or `rst`. A mismatching period deasserts it in the same cycle its `period_valid` asserts.
- Reset:
  - `rst` is high: go to ARM, and clear `tick_cnt`, `sat_flag`, `match_cnt` and the `last_period` valid bit.
  - All outputs reset to 0: `period=0`, `period_valid=0`, `overflow=0`, `locked=0`.
  - `rst` has priority over a simultaneous `strobe`; that strobe is ignored, including for arming.
- Reset mid-interval discards the partial count. The next strobe only re-arms.

## Timing
- Latency: a strobe at cycle t produces `period_valid` high in cycle t+1, with `period`, `overflow` and `locked` valid from t+1.
- `period_valid` never stays high for two consecutive cycles unless strobes arrive in consecutive cycles.
- Strobes may arrive every cycle. Throughput is one measurement per cycle.
- All outputs are registered, with no combinational input-to-output path.
- Width rules:
  - `tick_cnt` and `period` are WIDTH bits.
  - `match_cnt` is wide enough for `LOCK_COUNT-1`. A minimum of 1 bit is used.
  - Equality compares the full WIDTH bits.

## Test plan
- Arming and lock (`LOCK_COUNT=2`):
  - Stimulus: reset, hold `enable` high, strobe at cycles 10, 16 and 22.
  - Required response: no `period_valid` at 11; `period=6` with `period_valid` at 17 and 23; `locked` 0 at 17 and 1 at 23.
- Qualified ticks:
  - Stimulus: `enable` alternating 1/0, strobe every 8 cycles.
  - Required response: `period=4` each interval, `locked=1` from the second measurement.
- Zero and boundary tick:
  - Stimulus: strobes in cycles 20 and 21 with `enable` low, then `enable` high only at 21, then a strobe at 25.
  - Required response: `period=0` at 22; `period=1` at 26. The enable coinciding with the strobe at 21 counts toward the next interval.
- Saturation (`WIDTH=4`):
  - Stimulus: 20 enables between strobes.
  - Required response: `period=15`, `overflow=1`, `locked=0`, `match_cnt` cleared. The next 15-tick interval reports `overflow=0`.
- Lock loss:
  - Stimulus: periods 6, 6, 7.
  - Required response: `locked` is 1 after the second 6 and returns to 0 in the `period_valid` cycle of the 7.
- Reset interactions:
  - Stimulus: assert `rst` mid-interval, then assert `rst` together with `strobe`.
  - Required response: all outputs 0 on the cycle after `rst`. The first strobe after `rst` deasserts only arms the block, with no `period_valid`. A strobe coincident with `rst` neither arms nor reports.
